muldiv_ctrl: RTL and testbench

Sequencing controller for the EX-stage multiply and divide units. It accepts one HI/LO-class instruction at a time and drives the multiplier and the start/ready divider handshake. It raises the EX stall request for the duration of the operation and issues a single HI/LO write when the operation completes. Flush aborts any in-flight operation through the divider annul input.

---
 rtl/muldiv_ctrl_if.sv | 52 +++++
 rtl/muldiv_ctrl.sv | 145 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: signal bundle between the mul/div sequencing controller and
// its surroundings (EX stage, multiplier, divider, HI/LO register file).
//   master : controller side (muldiv_ctrl)
//   slave  : environment side (EX stage, mul unit, div unit, HI/LO)
// Signals:
//   flush, op_valid, op_sel[2:0], ex_hold, src_a[31:0], src_b[31:0]  EX -> ctrl
//   mul_signed, mul_ina[31:0], mul_inb[31:0]                          ctrl -> mul
//   mul_result[63:0]                                                   mul -> ctrl
//   div_start, div_signed, div_opdata1/2[31:0], div_annul              ctrl -> div
//   div_result[63:0] {remainder, quotient}, div_ready                  div -> ctrl
//   stallreq                                                           ctrl -> EX
//   hi_we, lo_we, hi_wdata[31:0], lo_wdata[31:0]                       ctrl -> HI/LO
interface muldiv_ctrl_if;
   logic        flush;
   logic        op_valid;
   logic [2:0]  op_sel;
   logic        ex_hold;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        mul_signed;
   logic [31:0] mul_ina;
   logic [31:0] mul_inb;
   logic [63:0] mul_result;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_opdata1;
   logic [31:0] div_opdata2;
   logic        div_annul;
   logic [63:0] div_result;
   logic        div_ready;
   logic        stallreq;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;

   modport master (
      input  flush, op_valid, op_sel, ex_hold, src_a, src_b,
      input  mul_result, div_result, div_ready,
      output mul_signed, mul_ina, mul_inb,
      output div_start, div_signed, div_opdata1, div_opdata2, div_annul,
      output stallreq, hi_we, lo_we, hi_wdata, lo_wdata
   );

   modport slave (
      output flush, op_valid, op_sel, ex_hold, src_a, src_b,
      output mul_result, div_result, div_ready,
      input  mul_signed, mul_ina, mul_inb,
      input  div_start, div_signed, div_opdata1, div_opdata2, div_annul,
      input  stallreq, hi_we, lo_we, hi_wdata, lo_wdata
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for the multiply and divide units.
// Accepts one HI/LO-class instruction at a time (mult, multu, div, divu,
// mthi, mtlo), drives the multiplier operands and the divider start/ready
// handshake, stalls EX while an operation is in flight and issues a single
// HI/LO write on completion. Flush aborts the operation (annulling the divider).
// Parameters:
//   MUL_LAT       cycles from operand presentation to valid mul_result (1..7)
//   DIV_ZERO_SKIP 1 = divide by zero completes in one cycle without a write
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  muldiv_ctrl_if master modport (EX, mul, div and HI/LO signals)
module muldiv_ctrl #(
   parameter int unsigned MUL_LAT       = 2,
   parameter bit          DIV_ZERO_SKIP = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_BUSY, DONE} state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   state_t      state;
   logic [2:0]  cnt;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        sgn;
   logic [63:0] result;
   logic        first;     // set only in the first DONE cycle
   logic        nowrite;   // divide-by-zero skip: DONE without a write

   logic        kill;
   logic        in_idle;
   logic        issue_mul;
   logic        issue_div;
   logic        done_we;
   logic        mthi_we;
   logic        mtlo_we;

   always_comb begin
      kill      = rst | bus.flush;
      in_idle   = (state == IDLE);
      issue_mul = in_idle & bus.op_valid & ((bus.op_sel == OP_MULT) | (bus.op_sel == OP_MULTU));
      issue_div = in_idle & bus.op_valid & ((bus.op_sel == OP_DIV)  | (bus.op_sel == OP_DIVU));
      done_we   = ~kill & (state == DONE) & first & ~nowrite;
      mthi_we   = ~kill & in_idle & bus.op_valid & (bus.op_sel == OP_MTHI);
      mtlo_we   = ~kill & in_idle & bus.op_valid & (bus.op_sel == OP_MTLO);

      bus.stallreq    = ~kill & (issue_mul | issue_div | (state == MUL_WAIT) | (state == DIV_BUSY));
      // start drops combinationally in the capture cycle so the divider
      // does not see a fresh start on the same edge it delivers the result
      bus.div_start   = ~kill & (state == DIV_BUSY) & ~bus.div_ready;
      bus.div_annul   = ~rst & bus.flush & (state == DIV_BUSY);
      bus.div_signed  = sgn;
      bus.div_opdata1 = opa;
      bus.div_opdata2 = opb;
      bus.mul_signed  = sgn;
      bus.mul_ina     = opa;
      bus.mul_inb     = opb;

      bus.hi_we    = done_we | mthi_we;
      bus.lo_we    = done_we | mtlo_we;
      bus.hi_wdata = '0;
      bus.lo_wdata = '0;
      if (done_we) begin
         bus.hi_wdata = result[63:32];
         bus.lo_wdata = result[31:0];
      end else begin
         if (mthi_we) bus.hi_wdata = bus.src_a;
         if (mtlo_we) bus.lo_wdata = bus.src_a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         opa     <= '0;
         opb     <= '0;
         sgn     <= 1'b0;
         result  <= '0;
         first   <= 1'b0;
         nowrite <= 1'b0;
      end else if (bus.flush) begin
         state   <= IDLE;
         first   <= 1'b0;
         nowrite <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (issue_mul) begin
                  opa   <= bus.src_a;
                  opb   <= bus.src_b;
                  sgn   <= (bus.op_sel == OP_MULT);
                  cnt   <= 3'(MUL_LAT - 1);
                  state <= MUL_WAIT;
               end else if (issue_div) begin
                  opa <= bus.src_a;
                  opb <= bus.src_b;
                  sgn <= (bus.op_sel == OP_DIV);
                  if (DIV_ZERO_SKIP && (bus.src_b == '0)) begin
                     state   <= DONE;
                     first   <= 1'b1;
                     nowrite <= 1'b1;
                  end else begin
                     state <= DIV_BUSY;
                  end
               end
            end
            MUL_WAIT: begin
               if (cnt == '0) begin
                  result  <= bus.mul_result;
                  state   <= DONE;
                  first   <= 1'b1;
                  nowrite <= 1'b0;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            DIV_BUSY: begin
               if (bus.div_ready) begin
                  result  <= bus.div_result;
                  state   <= DONE;
                  first   <= 1'b1;
                  nowrite <= 1'b0;
               end
            end
            DONE: begin
               first <= 1'b0;
               if (!bus.ex_hold) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed-vector bench for muldiv_ctrl. Models a multiplier
// with MUL_LAT-cycle latency and a start/ready divider with programmable
// latency; expected HI/LO writes are queued at issue and matched by a
// monitor whenever the controller strobes hi_we/lo_we.
module tb_muldiv_ctrl;

   localparam int unsigned MUL_LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_ctrl_if bus ();

   muldiv_ctrl #(
      .MUL_LAT      (MUL_LAT),
      .DIV_ZERO_SKIP(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // multiplier model: one register stage after the registered operands
   logic [63:0] mul_a64, mul_b64, mul_prod, mul_q;
   always_comb begin
      mul_a64  = bus.mul_signed ? {{32{bus.mul_ina[31]}}, bus.mul_ina} : {32'b0, bus.mul_ina};
      mul_b64  = bus.mul_signed ? {{32{bus.mul_inb[31]}}, bus.mul_inb} : {32'b0, bus.mul_inb};
      mul_prod = mul_a64 * mul_b64;
   end
   always_ff @(posedge clk) mul_q <= mul_prod;
   assign bus.mul_result = mul_q;

   // divider model: ready in the div_lat-th cycle of continuous start
   int unsigned div_lat = 33;
   int unsigned div_cnt;
   logic [31:0] dq, dr;
   always_ff @(posedge clk) begin
      if (bus.div_start) div_cnt <= div_cnt + 1;
      else               div_cnt <= 0;
   end
   always_comb begin
      dq = '1;
      dr = bus.div_opdata1;
      if (bus.div_opdata2 != '0) begin
         if (bus.div_signed) begin
            dq = 32'($signed(bus.div_opdata1) / $signed(bus.div_opdata2));
            dr = 32'($signed(bus.div_opdata1) % $signed(bus.div_opdata2));
         end else begin
            dq = bus.div_opdata1 / bus.div_opdata2;
            dr = bus.div_opdata1 % bus.div_opdata2;
         end
      end
   end
   assign bus.div_result = {dr, dq};
   assign bus.div_ready  = (div_cnt == div_lat - 1);

   logic out_or;
   assign out_or = |{bus.stallreq, bus.hi_we, bus.lo_we, bus.hi_wdata, bus.lo_wdata,
                     bus.div_start, bus.div_annul, bus.div_signed, bus.div_opdata1,
                     bus.div_opdata2, bus.mul_signed, bus.mul_ina, bus.mul_inb};

   // scoreboard
   typedef struct packed {
      logic        hw;
      logic        lw;
      logic [31:0] hd;
      logic [31:0] ld;
   } wr_t;
   wr_t   exp_q[$];
   string name_q[$];
   wr_t   mon_e;
   string mon_n;

   always @(negedge clk) begin
      if (bus.hi_we || bus.lo_we) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL write_unexpected: got hi_we=%0b lo_we=%0b hi=%h lo=%h, required no write",
                     bus.hi_we, bus.lo_we, bus.hi_wdata, bus.lo_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            if (bus.hi_we !== mon_e.hw || bus.lo_we !== mon_e.lw ||
                (mon_e.hw && bus.hi_wdata !== mon_e.hd) ||
                (mon_e.lw && bus.lo_wdata !== mon_e.ld)) begin
               n_err++;
               $display("FAIL write_%s: got we=%0b%0b hi=%h lo=%h, required we=%0b%0b hi=%h lo=%h",
                        mon_n, bus.hi_we, bus.lo_we, bus.hi_wdata, bus.lo_wdata,
                        mon_e.hw, mon_e.lw, mon_e.hd, mon_e.ld);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, got, want);
      end
   endtask

   task automatic expect_wr(input string name, input logic hw, input logic lw,
                            input logic [31:0] hd, input logic [31:0] ld);
      exp_q.push_back({hw, lw, hd, ld});
      name_q.push_back(name);
   endtask

   // Issue one instruction, count stall cycles, then hold EX for `hold`
   // DONE cycles. While busy, op_sel/src are scribbled to prove they are ignored.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int unsigned exp_stall, input int unsigned hold);
      int unsigned stalls = 0;
      int unsigned guard  = 0;
      int unsigned bad    = 0;
      logic        st;
      logic        is_div;
      is_div       = (op == 3'd2) || (op == 3'd3);
      bus.op_valid = 1'b1;
      bus.op_sel   = op;
      bus.src_a    = a;
      bus.src_b    = b;
      bus.ex_hold  = (hold != 0);
      do begin
         @(negedge clk);
         st = bus.stallreq;
         if (st) stalls++;
         if (guard > 0 && st && (bus.div_start !== (is_div && !bus.div_ready))) bad++;
         tick();
         guard++;
         bus.op_sel = 3'd5;
         bus.src_a  = 32'hDEAD_BEEF;
         bus.src_b  = 32'h0000_0001;
      end while (st && guard < 200);
      if (guard >= 200) check({name, "_timeout"}, 64'(guard), 64'(exp_stall));
      check({name, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
      check({name, "_div_start"}, 64'(bad), 64'd0);
      for (int unsigned h = 1; h < hold; h++) begin
         bus.op_sel = op;
         bus.src_a  = a;
         bus.src_b  = b;
         @(negedge clk);
         check({name, "_no_restart_in_hold"}, 64'(bus.stallreq), 64'd0);
         tick();
      end
      bus.op_valid = 1'b0;
      bus.op_sel   = 3'd0;
      bus.ex_hold  = 1'b0;
      tick();
   endtask

   initial begin
      bus.flush    = 1'b0;
      bus.op_valid = 1'b0;
      bus.op_sel   = 3'd0;
      bus.ex_hold  = 1'b0;
      bus.src_a    = '0;
      bus.src_b    = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", 64'(out_or), 64'd0);
      tick();

      // -2 * 3 = -6
      expect_wr("mult", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, MUL_LAT + 1, 0);

      // -2^31 * 2 = -2^32, completed under a 3-cycle EX hold
      expect_wr("mult_hold", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
      run_op("mult_hold", 3'd0, 32'h8000_0000, 32'd2, MUL_LAT + 1, 3);

      div_lat = 33;
      expect_wr("divu", 1'b1, 1'b1, 32'd2, 32'd14);
      run_op("divu", 3'd3, 32'd100, 32'd7, 34, 0);

      run_op("div_zero", 3'd2, 32'd5, 32'd0, 1, 0);

      // -7 / 2 = -3 rem -1
      div_lat = 5;
      expect_wr("div_signed", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_signed", 3'd2, 32'hFFFF_FFF9, 32'd2, 6, 0);

      expect_wr("mtlo", 1'b0, 1'b1, 32'h0, 32'hCAFE_F00D);
      run_op("mtlo", 3'd5, 32'hCAFE_F00D, 32'd0, 0, 0);

      run_op("noop", 3'd7, 32'h1111_1111, 32'h2222_2222, 0, 0);

      // flush five cycles into a divide, then multu the next cycle
      div_lat      = 33;
      bus.op_valid = 1'b1;
      bus.op_sel   = 3'd2;
      bus.src_a    = 32'd50;
      bus.src_b    = 32'd5;
      tick();
      bus.op_valid = 1'b0;
      repeat (4) tick();
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush_div_annul", 64'(bus.div_annul), 64'd1);
      check("flush_stallreq", 64'(bus.stallreq), 64'd0);
      tick();
      bus.flush = 1'b0;
      expect_wr("multu_after_flush", 1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("multu_after_flush", 3'd1, 32'hFFFF_FFFF, 32'd2, MUL_LAT + 1, 0);

      // reset lands on the divider's ready cycle
      div_lat      = 4;
      bus.op_valid = 1'b1;
      bus.op_sel   = 3'd3;
      bus.src_a    = 32'd9;
      bus.src_b    = 32'd4;
      tick();
      bus.op_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_outputs", 64'(out_or), 64'd0);
      tick();
      expect_wr("mthi", 1'b1, 1'b0, 32'h0000_1234, 32'h0);
      run_op("mthi", 3'd4, 32'h0000_1234, 32'd0, 0, 0);

      repeat (3) tick();
      check("pending_writes", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required completion within 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
